// File: rtl/uart_cfg_frame_tx.sv
// Round-robin register-write framer for the UART config link.
// Frames: HEAD0 HEAD1 ch addr(LE) value(LE) [checksum].
module uart_cfg_frame_tx #(
  parameter logic [7:0] UART_HEAD0 = 8'hFF,
  parameter logic [7:0] UART_HEAD1 = 8'hAA,
  parameter int N_CH = 2,
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 2,
  parameter bit CSUM_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  output logic [7:0] tx_data,
  output logic tx_vld,
  input  logic tx_ready,
  input  logic [N_CH*8*ADDR_BYTES-1:0] cfg_addr,
  input  logic [N_CH*8*DATA_BYTES-1:0] cfg_value,
  input  logic [N_CH-1:0] cfg_req,
  output logic [N_CH-1:0] cfg_done,
  output logic busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int PB = ADDR_BYTES + DATA_BYTES;
  localparam int L  = 3 + PB + (CSUM_EN ? 1 : 0);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_n;

  logic [N_CH-1:0]   req_d;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   clr;
  logic              armed;
  logic [CW-1:0]     last_grant;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     win;
  logic              found;
  int                rr_base;
  logic [2*N_CH-1:0] dbl;
  logic [3:0]        byte_cnt;
  logic [3:0]        nidx;
  logic [7:0]        nbyte;
  logic [8*PB-1:0]   payload;
  logic [7:0]        csum;
  logic              load;
  logic              xfer;
  logic              last;

  assign busy   = (state == SEND);
  assign tx_vld = busy;
  assign xfer   = busy & tx_ready;
  assign last   = (byte_cnt == 4'(L - 1));
  assign load   = (state == IDLE) & found;
  assign nidx   = byte_cnt + 4'd1;

  // A level held through reset is absorbed on the first clock after reset
  assign rise = cfg_req & ~req_d & {N_CH{armed}};
  assign clr  = load ? (N_CH'(1) << win) : '0;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    rr_base = (int'(last_grant) + 1) % N_CH;
    dbl     = {pending, pending} >> rr_base;
    win     = last_grant;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        win   = CW'((rr_base + i) % N_CH);
      end
    end
  end

  // Channel is done when nothing queued and its frame is not on the wire
  always_comb begin
    cfg_done = '1;
    for (int i = 0; i < N_CH; i++)
      cfg_done[i] = ~pending[i] & ~(busy & (grant == CW'(i)));
  end

  // Edge detect and pending set/clear; a same-cycle re-request survives grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d   <= '0;
      pending <= '0;
      armed   <= 1'b0;
    end else begin
      req_d   <= cfg_req;
      armed   <= 1'b1;
      pending <= (pending & ~clr) | rise;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (found) state_n = SEND;
      SEND:    if (xfer && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Byte following the one currently presented
  always_comb begin
    nbyte = csum;
    if (nidx == 4'd1)
      nbyte = UART_HEAD1;
    else if (nidx == 4'd2)
      nbyte = 8'(grant);
    else if (nidx < 4'(3 + PB))
      nbyte = payload[7:0];
  end

  // Frame datapath: load on grant, advance one byte per transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= 8'h00;
      byte_cnt   <= 4'd0;
      payload    <= '0;
      csum       <= 8'h00;
      grant      <= '0;
      last_grant <= CW'(N_CH - 1);
    end else if (load) begin
      tx_data    <= UART_HEAD0;
      byte_cnt   <= 4'd0;
      payload    <= {DW'(cfg_value >> (int'(win) * DW)),
                     AW'(cfg_addr >> (int'(win) * AW))};
      csum       <= 8'(win);
      grant      <= win;
      last_grant <= win;
    end else if (xfer) begin
      byte_cnt <= nidx;
      if (last) begin
        tx_data <= 8'h00;
      end else begin
        tx_data <= nbyte;
        if (nidx >= 4'd3 && nidx < 4'(3 + PB)) begin
          payload <= payload >> 8;
          csum    <= csum + payload[7:0];
        end
      end
    end
  end

endmodule
